// File: rtl/nios_security_led_pwm.sv
// nios_security_led_pwm
// Turns the Nios LED PIO word into per-LED PWM brightness. Each LED i owns
// duty nibble ctrl_in[4i+3:4i]. The word is copied into a shadow register only
// at PWM period boundaries, so a software write never produces a partial period.
//
// Build option: define LED_PWM_BLINK_EN to reinterpret each nibble as
// {blink_flag, coarse_duty[2:0]} and add a slow blink phase driven by
// BLINK_PERIODS. With the macro undefined the nibble is a plain 4-bit duty and
// no blink state exists.
module nios_security_led_pwm #(
  parameter int unsigned PRESCALE      = 1000,
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned BLINK_PERIODS = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ctrl_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                period_start,
  output logic [31:0]         shadow_word
);

  // Out-of-range parameters are rejected at elaboration time.
  if ((PRESCALE < 1) || (PRESCALE > 65536) || (NUM_LEDS < 1) || (NUM_LEDS > 8) ||
      (BLINK_PERIODS < 1)) begin : g_param_check
    $error("nios_security_led_pwm: illegal parameter value");
  end

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [3:0]  PWM_LAST   = 4'd14;

  // Maps a shadow nibble to the compare threshold for its LED.
  function automatic logic [3:0] nibble_duty(input logic [3:0] nib);
`ifdef LED_PWM_BLINK_EN
    if (nib[2:0] == 3'd0) begin
      return 4'd0;
    end else begin
      return {nib[2:0], 1'b1};
    end
`else
    return nib;
`endif
  endfunction

  logic [15:0]         prescaler_q, prescaler_d;
  logic [3:0]          pwm_cnt_q,   pwm_cnt_d;
  logic [31:0]         shadow_q,    shadow_d;
  logic                period_start_q, period_start_d;
  logic [NUM_LEDS-1:0] led_q,       led_d;
  logic                tick_s;
  logic                boundary_s;

  // Step tick and period boundary decode from the free-running counters.
  always_comb begin
    tick_s     = (prescaler_q == PRESC_LAST);
    boundary_s = tick_s && (pwm_cnt_q == PWM_LAST);
  end

  // Counter, shadow and period_start next-state logic.
  always_comb begin
    prescaler_d    = prescaler_q;
    pwm_cnt_d      = pwm_cnt_q;
    shadow_d       = shadow_q;
    period_start_d = 1'b0;
    if (tick_s) begin
      prescaler_d = 16'd0;
      if (pwm_cnt_q == PWM_LAST) begin
        pwm_cnt_d = 4'd0;
      end else begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
      end
    end else begin
      prescaler_d = prescaler_q + 16'd1;
      pwm_cnt_d   = pwm_cnt_q;
    end
    if (boundary_s) begin
      shadow_d       = ctrl_in;
      period_start_d = 1'b1;
    end else begin
      shadow_d       = shadow_q;
      period_start_d = 1'b0;
    end
  end

`ifdef LED_PWM_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Blink counter advances once per period; the phase flips when it wraps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
      end
    end else begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  // Per-LED compare against the applied duty; blink masking shares this stage.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      led_d[i] = (pwm_cnt_q < nibble_duty(shadow_q[4*i +: 4]));
`ifdef LED_PWM_BLINK_EN
      if (blink_phase_q && shadow_q[4*i+3]) begin
        led_d[i] = 1'b0;
      end else begin
        led_d[i] = led_d[i];
      end
`endif
    end
  end

  // Counter, shadow and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q    <= 16'd0;
      pwm_cnt_q      <= 4'd0;
      shadow_q       <= 32'd0;
      period_start_q <= 1'b0;
      led_q          <= '0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      shadow_q       <= shadow_d;
      period_start_q <= period_start_d;
      led_q          <= led_d;
    end
  end

  assign led_out      = led_q;
  assign period_start = period_start_q;
  assign shadow_word  = shadow_q;

endmodule
